decoded_divider: RTL and testbench
==================================

DECODED_DIVIDER -- requirements
Module: decoded_divider

Interface
REQ-001 Parameter STAGES, default 8, number of decoded outputs; legal range 2..16.
REQ-002 Derived localparam W = clog2(STAGES), minimum 1; this is the width of the state index.
REQ-003 CLOCK  in  1  clock; all state updates on the rising edge.
REQ-004 RESET  in  1  reset; synchronous, active-high.
REQ-005 CLOCK_INHIBIT  in  1  when high, counting is held; LOAD still acts.
REQ-006 DIR  in  1  count direction: 0 = up, 1 = down.
REQ-007 LAST  in  W  index of the final state; modulus = LAST_EFF+1.
REQ-008 LOAD  in  1  synchronous preset strobe.
REQ-009 LOAD_VAL  in  W  preset state index.
REQ-010 OUT  out  STAGES  one-hot decode of the current state; OUT[i] is high iff COUNT == i.
REQ-011 COUNT  out  W  current state index, taken directly from the register.
REQ-012 CARRY_OUT  out  1  high during the first half of the cycle: COUNT <= LAST_EFF/2, integer divide.
REQ-013 TC  out  1  terminal-count flag; combinational from the state, DIR, LAST_EFF and CLOCK_INHIBIT.

Function
REQ-014 LAST_EFF SHALL be computed as follows:
- LAST >= STAGES -> STAGES-1
- LAST == 0 -> 1
- otherwise LAST
REQ-015 Per-edge priority SHALL be RESET > LOAD > CLOCK_INHIBIT > count.
REQ-016 LOAD SHALL set COUNT to LOAD_VAL, or to 0 if LOAD_VAL > LAST_EFF, regardless of CLOCK_INHIBIT and DIR.
REQ-017 Up count (DIR=0, no inhibit, no load): COUNT SHALL go to 0 if COUNT >= LAST_EFF, else COUNT+1.
REQ-018 Down count (DIR=1): COUNT SHALL go to LAST_EFF if COUNT == 0 or COUNT > LAST_EFF, else COUNT-1.
REQ-019 CLOCK_INHIBIT high with LOAD low SHALL hold COUNT, OUT and CARRY_OUT unchanged.
REQ-020 OUT, CARRY_OUT and TC SHALL reflect the COUNT register in the same cycle, with zero latency and no lag of one state.
REQ-021 OUT SHALL be exactly one-hot in every cycle, including after reset, load, and a LAST change.
REQ-022 TC SHALL be high iff CLOCK_INHIBIT is low and either:
- DIR=0 and COUNT >= LAST_EFF, or
- DIR=1 and COUNT == 0.
REQ-023 TC SHALL go high exactly in the cycle whose next edge wraps the count.
REQ-024 A LAST change mid-sequence SHALL take effect on the next edge per REQ-017/018; an out-of-range COUNT SHALL recover within one active edge.
REQ-025 A DIR change SHALL take effect on the next active edge, with no skipped or repeated state beyond the direction reversal.
REQ-026 A divide-by-N square wave SHALL be available on CARRY_OUT with period LAST_EFF+1 active edges.
REQ-027 No internal state SHALL exist beyond the COUNT register; all other outputs are decoded from it.

Reset
REQ-028 While RESET is high at a rising edge, the block SHALL take the reset state:
- COUNT=0
- OUT = 1 in bit 0 only
- CARRY_OUT=1
REQ-029 TC after reset SHALL follow REQ-022, e.g. TC=1 if DIR=1 and CLOCK_INHIBIT=0.
REQ-030 RESET SHALL override LOAD and CLOCK_INHIBIT on the same edge.
REQ-031 The block SHALL not depend on an initial block for correct operation; behaviour before the first RESET is don't-care.
REQ-032 Reset applied mid-sequence SHALL return the block to the reset state on that edge, with no partial update.

Verification (STAGES=8 unless stated)
REQ-033 Up wrap:
- Stimulus: LAST=7, DIR=0, 10 edges after reset.
- Response: COUNT 1,2,...,7,0,1,2; OUT walks bit 1 to bit 7, then back to bit 0.
- CARRY_OUT high for COUNT 0-3; TC high only while COUNT=7.
REQ-034 Modulus 5:
- Stimulus: LAST=4.
- Response: sequence 0,1,2,3,4,0; CARRY_OUT high for 0-2 and low for 3-4; TC at 4.
- Stimulus: LAST=12.
- Response: LAST_EFF=7.
REQ-035 Down and reversal:
- Stimulus: DIR=1 from COUNT=0.
- Response: 7,6,5.
- Stimulus: DIR=0 at COUNT=5.
- Response: 6,7,0.
REQ-036 Inhibit and load:
- Stimulus: CLOCK_INHIBIT=1 at COUNT=3 for 4 edges.
- Response: COUNT stays 3 and TC=0.
- Stimulus: LOAD=1, LOAD_VAL=6 while inhibited.
- Response: COUNT=6.
- Stimulus: LOAD_VAL=6 with LAST=4.
- Response: COUNT=0.
REQ-037 Priority:
- Stimulus: RESET=1 with LOAD=1, LOAD_VAL=5, CLOCK_INHIBIT=1.
- Response: COUNT=0, OUT=00000001.
- Stimulus: LAST changed 7->2 at COUNT=5, DIR=0.
- Response: next COUNT=0.
REQ-038 Parameter sweep:
- Stimulus: STAGES=2 and STAGES=16, full up cycle at max LAST.
- Response: OUT one-hot every cycle; wrap occurs at 1 and at 15 respectively.

Source files
------------

// File: rtl/decoded_divider.sv
// Decoded modulo-N up/down counter with one-hot state decode,
// divide-by-N square wave on CARRY_OUT and a terminal-count flag.
module decoded_divider #(
   parameter  int STAGES = 8,
   localparam int W      = (STAGES > 2) ? $clog2(STAGES) : 1
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              CLOCK_INHIBIT,
   input  logic              DIR,
   input  logic [W-1:0]      LAST,
   input  logic              LOAD,
   input  logic [W-1:0]      LOAD_VAL,
   output logic [STAGES-1:0] OUT,
   output logic [W-1:0]      COUNT,
   output logic              CARRY_OUT,
   output logic              TC
);

   localparam logic [W:0]   STAGES_X = (W+1)'(STAGES);
   localparam logic [W-1:0] MAX_IDX  = W'(STAGES - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic [W-1:0] last_eff;
   logic         at_top;
   logic         at_zero;

   always_comb begin
      last_eff = LAST;
      if ({1'b0, LAST} >= STAGES_X) begin
         last_eff = MAX_IDX;
      end else if (LAST == '0) begin
         last_eff = W'(1);
      end
   end

   assign at_top  = (count_q >= last_eff);
   assign at_zero = (count_q == '0);

   // Out-of-range counts (after a LAST change) fold back in one edge.
   always_comb begin
      count_d = count_q;
      priority case (1'b1)
         LOAD: begin
            count_d = (LOAD_VAL > last_eff) ? '0 : LOAD_VAL;
         end
         CLOCK_INHIBIT: begin
            count_d = count_q;
         end
         !DIR: begin
            count_d = at_top ? '0 : count_q + W'(1);
         end
         default: begin
            if (at_zero || (count_q > last_eff)) begin
               count_d = last_eff;
            end else begin
               count_d = count_q - W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         OUT[i] = (count_q == W'(i));
      end
   end

   assign COUNT     = count_q;
   assign CARRY_OUT = (count_q <= (last_eff >> 1));
   assign TC        = !CLOCK_INHIBIT && (DIR ? at_zero : at_top);

endmodule

// File: tb/tb_decoded_divider.sv
// Bench for decoded_divider: directed literal sequences plus randomized
// stimulus checked every cycle against a behavioural counter model.
module tb_decoded_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inh = 1'b0;
   logic       dir = 1'b0;
   logic       ld  = 1'b0;
   logic [2:0] last = 3'd7;
   logic [2:0] lv   = 3'd0;

   logic [7:0]  out8;
   logic [2:0]  c8;
   logic        cy8, tc8;
   logic [1:0]  out2;
   logic [0:0]  c2;
   logic        cy2, tc2;
   logic [15:0] out16;
   logic [3:0]  c16;
   logic        cy16, tc16;

   int errors = 0;
   int checks = 0;
   int m8 = -1;
   int m2 = -1;
   int m16 = -1;
   int e8;

   int m5c[5] = '{1, 2, 3, 4, 0};
   int m5y[5] = '{1, 1, 0, 0, 1};
   int m5t[5] = '{0, 0, 0, 1, 0};
   int dnc[6] = '{7, 6, 5, 6, 7, 0};

   always #5 clk = ~clk;

   decoded_divider #(.STAGES(8)) u8 (
      .CLOCK(clk), .RESET(rst), .CLOCK_INHIBIT(inh), .DIR(dir),
      .LAST(last), .LOAD(ld), .LOAD_VAL(lv),
      .OUT(out8), .COUNT(c8), .CARRY_OUT(cy8), .TC(tc8)
   );

   decoded_divider #(.STAGES(2)) u2 (
      .CLOCK(clk), .RESET(rst), .CLOCK_INHIBIT(1'b0), .DIR(1'b0),
      .LAST(1'b1), .LOAD(1'b0), .LOAD_VAL(1'b0),
      .OUT(out2), .COUNT(c2), .CARRY_OUT(cy2), .TC(tc2)
   );

   decoded_divider #(.STAGES(16)) u16 (
      .CLOCK(clk), .RESET(rst), .CLOCK_INHIBIT(1'b0), .DIR(1'b0),
      .LAST(4'hF), .LOAD(1'b0), .LOAD_VAL(4'h0),
      .OUT(out16), .COUNT(c16), .CARRY_OUT(cy16), .TC(tc16)
   );

   function automatic int leff(int l, int stages);
      if (l >= stages) return stages - 1;
      if (l == 0) return 1;
      return l;
   endfunction

   function automatic int nxt(int m, int stages, bit r, bit l,
                              int v, bit ih, bit d, int lst);
      int e;
      e = leff(lst, stages);
      if (r) return 0;
      if (m < 0) return -1;
      if (l) return (v > e) ? 0 : v;
      if (ih) return m;
      if (!d) return (m >= e) ? 0 : m + 1;
      return (m == 0 || m > e) ? e : m - 1;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      m8  <= nxt(m8, 8, rst, ld, int'(lv), inh, dir, int'(last));
      m2  <= nxt(m2, 2, rst, 1'b0, 0, 1'b0, 1'b0, 1);
      m16 <= nxt(m16, 16, rst, 1'b0, 0, 1'b0, 1'b0, 15);
   end

   always @(negedge clk) begin
      if (m8 >= 0) begin
         e8 = leff(int'(last), 8);
         chk("count8", 32'(c8), m8);
         chk("out8", 32'(out8), 32'd1 << m8);
         chk("carry8", 32'(cy8), 32'(m8 <= e8 / 2));
         chk("tc8", 32'(tc8), 32'(!inh && (dir ? m8 == 0 : m8 >= e8)));
         chk("count2", 32'(c2), m2);
         chk("out2", 32'(out2), 32'd1 << m2);
         chk("tc2", 32'(tc2), 32'(m2 >= 1));
         chk("count16", 32'(c16), m16);
         chk("out16", 32'(out16), 32'd1 << m16);
         chk("carry16", 32'(cy16), 32'(m16 <= 7));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_count", 32'(c8), 0);
      chk("rst_out", 32'(out8), 32'h01);
      chk("rst_carry", 32'(cy8), 1);
      chk("rst_tc_up", 32'(tc8), 0);
      dir = 1'b1;
      #1;
      chk("rst_tc_down", 32'(tc8), 1);
      dir = 1'b0;
      rst = 1'b0;

      for (int e = 1; e <= 17; e++) begin
         tick();
         chk("up8", 32'(c8), e % 8);
         chk("up2", 32'(c2), e % 2);
         chk("up16", 32'(c16), e % 16);
         if (e == 3) chk("carry_at3", 32'(cy8), 1);
         if (e == 4) chk("carry_at4", 32'(cy8), 0);
         if (e == 7) chk("tc_at7", 32'(tc8), 1);
         if (e == 15) chk("tc16_at15", 32'(tc16), 1);
      end

      last = 3'd4;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mod5_count", 32'(c8), m5c[i]);
         chk("mod5_carry", 32'(cy8), m5y[i]);
         chk("mod5_tc", 32'(tc8), m5t[i]);
      end

      last = 3'd0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("last0", 32'(c8), (i + 1) % 2);
      end

      last = 3'd7;
      do_reset();
      dir = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) dir = 1'b0;
         tick();
         chk("down_rev", 32'(c8), dnc[i]);
      end

      do_reset();
      repeat (3) tick();
      chk("pre_inh", 32'(c8), 3);
      inh = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("inh_hold", 32'(c8), 3);
         chk("inh_tc", 32'(tc8), 0);
      end
      ld = 1'b1;
      lv = 3'd6;
      tick();
      chk("load_inh", 32'(c8), 6);
      last = 3'd4;
      tick();
      chk("load_range", 32'(c8), 0);
      ld = 1'b0;
      inh = 1'b0;

      last = 3'd7;
      ld = 1'b1;
      lv = 3'd5;
      tick();
      chk("load5", 32'(c8), 5);
      rst = 1'b1;
      inh = 1'b1;
      tick();
      chk("prio_count", 32'(c8), 0);
      chk("prio_out", 32'(out8), 32'h01);
      rst = 1'b0;
      inh = 1'b0;
      tick();
      chk("reload5", 32'(c8), 5);
      ld = 1'b0;
      last = 3'd2;
      tick();
      chk("shrink_up", 32'(c8), 0);
      ld = 1'b1;
      last = 3'd7;
      tick();
      ld = 1'b0;
      last = 3'd2;
      dir = 1'b1;
      tick();
      chk("shrink_down", 32'(c8), 2);
      dir = 1'b0;

      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         ld  = ($urandom_range(0, 7) == 0);
         lv  = 3'($urandom);
         inh = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 9) == 0) dir = ~dir;
         if ($urandom_range(0, 15) == 0) last = 3'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
